// File: rtl/psdi_decim_interp_if.sv
// Sample-stream bundle between the right-channel lowpass and the decimate/interpolate stage.
interface psdi_decim_interp_if #(
   parameter int unsigned DW = 18
);
   logic                 data_en;
   logic [1:0]           dec_sel;
   logic                 bypass;
   logic signed [DW-1:0] datain;
   logic signed [DW-1:0] dataout;
   logic                 dout_valid;
   logic                 anchor_strobe;

   modport master (
      output data_en, dec_sel, bypass, datain,
      input  dataout, dout_valid, anchor_strobe
   );

   modport slave (
      input  data_en, dec_sel, bypass, datain,
      output dataout, dout_valid, anchor_strobe
   );
endinterface

// File: rtl/psdi_decim_interp.sv
// Keeps one sample in D (D = 1,2,4,8) and rebuilds a full-rate stream by
// linear interpolation between consecutive kept anchors; bypass is a registered pass-through.
module psdi_decim_interp #(
   parameter int unsigned DW    = 18,
   parameter int unsigned MAXSH = 3
) (
   input  logic              clock,
   input  logic              reset,
   psdi_decim_interp_if.slave bus
);
   localparam int unsigned PW = DW + 1 + MAXSH;
   localparam int unsigned SW = 2;

   logic [MAXSH-1:0]     k_q, k_n, k_last;
   logic [SW-1:0]        s_q, s_n;
   logic signed [DW-1:0] prev_q, cur_q, prev_n, cur_n, interp;
   logic signed [PW-1:0] diff, prod, shifted, sum;
   logic                 anchor;

   // Post-update anchors/shift, then prev' + floor(diff*k / 2^s')
   always_comb begin
      anchor = (k_q == '0);
      s_n    = s_q;
      prev_n = prev_q;
      cur_n  = cur_q;
      if (anchor) begin
         s_n    = bus.dec_sel;
         prev_n = cur_q;
         cur_n  = bus.datain;
      end
      diff    = PW'(cur_n) - PW'(prev_n);
      prod    = diff * $signed(PW'({1'b0, k_q}));
      shifted = prod >>> s_n;
      sum     = PW'(prev_n) + shifted;
      interp  = sum[DW-1:0];
      k_last  = MAXSH'((32'd1 << s_n) - 32'd1);
      k_n     = (k_q == k_last) ? '0 : k_q + MAXSH'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         k_q               <= '0;
         s_q               <= '0;
         prev_q            <= '0;
         cur_q             <= '0;
         bus.dataout       <= '0;
         bus.dout_valid    <= 1'b0;
         bus.anchor_strobe <= 1'b0;
      end else begin
         bus.dout_valid    <= bus.data_en;
         bus.anchor_strobe <= bus.data_en & anchor;
         if (bus.data_en) begin
            k_q         <= k_n;
            s_q         <= s_n;
            prev_q      <= prev_n;
            cur_q       <= cur_n;
            bus.dataout <= bus.bypass ? bus.datain : interp;
         end
      end
   end
endmodule

// File: tb/tb_psdi_decim_interp.sv
// Self-checking bench: directed literal cases plus randomized traffic against an integer model.
module tb_psdi_decim_interp;
   localparam int unsigned DW = 18;

   logic clock;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   valid_cnt = 0;
   int   last_out;
   int   last_a;

   psdi_decim_interp_if #(.DW(DW)) bus ();

   psdi_decim_interp #(.DW(DW), .MAXSH(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase count, latched shift and two anchors as plain integers
   int m_k, m_s, m_prev, m_cur;
   int exp_out, exp_v, exp_a;

   function automatic int floor_div(input int num, input int den);
      if (num >= 0) return num / den;
      return -((-num + den - 1) / den);
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_k = 0; m_s = 0; m_prev = 0; m_cur = 0;
         exp_out = 0; exp_v = 0; exp_a = 0;
      end else begin
         exp_v = 0;
         exp_a = 0;
         if (bus.data_en) begin
            if (m_k == 0) begin
               m_s    = int'(bus.dec_sel);
               m_prev = m_cur;
               m_cur  = int'(bus.datain);
               exp_a  = 1;
            end
            exp_out = bus.bypass ? int'(bus.datain)
                                 : m_prev + floor_div((m_cur - m_prev) * m_k, 1 << m_s);
            exp_v   = 1;
            m_k     = (m_k + 1) % (1 << m_s);
         end
      end
   end

   // Cycle-by-cycle compare away from the active edge
   always @(negedge clock) begin
      chk("dataout", int'(bus.dataout), exp_out);
      chk("dout_valid", int'(bus.dout_valid), exp_v);
      chk("anchor_strobe", int'(bus.anchor_strobe), exp_a);
      if (bus.dout_valid) valid_cnt++;
   end

   task automatic send(input int din);
      bus.data_en = 1'b1;
      bus.datain  = DW'(din);
      @(posedge clock);
      #1;
      last_out = int'(bus.dataout);
      last_a   = int'(bus.anchor_strobe);
   endtask

   task automatic idle();
      bus.data_en = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1 reset = 1'b0;
   endtask

   int a_seen [12];

   initial begin
      reset       = 1'b1;
      bus.data_en = 1'b0;
      bus.dec_sel = 2'd0;
      bus.bypass  = 1'b0;
      bus.datain  = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("reset_dataout", int'(bus.dataout), 0);
      chk("reset_valid", int'(bus.dout_valid), 0);

      // Linear ramp, D=4
      bus.dec_sel = 2'd2;
      for (int i = 0; i < 9; i++) begin
         send((i % 4 == 0) ? 400 * (i / 4 + 1) : 7777);
         chk("ramp", last_out, 100 * i);
         chk("ramp_anchor", last_a, (i % 4 == 0) ? 1 : 0);
      end
      idle();

      // Floor rounding toward -inf, D=4
      do_reset(); idle();
      bus.dec_sel = 2'd2;
      send(0); send(11); send(22); send(33);
      for (int i = 0; i < 4; i++) begin
         send((i == 0) ? -3 : 55);
         chk("floor", last_out, -i);
      end
      idle();

      // Full-scale anchors
      do_reset(); idle();
      send(131071); send(1); send(2); send(3);
      send(-131072); chk("fs_k0", last_out, 131071);
      send(9);       chk("fs_k1", last_out, 65535);
      send(9);       chk("fs_k2", last_out, -1);
      send(9);       chk("fs_k3", last_out, -65537);
      idle();

      // D=1: one-sample delay, every sample an anchor
      do_reset(); idle();
      bus.dec_sel = 2'd0;
      send(5);  chk("d1_a", last_out, 0); chk("d1_anc", last_a, 1);
      send(7);  chk("d1_b", last_out, 5); chk("d1_anc", last_a, 1);
      send(-9); chk("d1_c", last_out, 7); chk("d1_anc", last_a, 1);
      bus.bypass = 1'b1;
      send(1234); chk("bypass", last_out, 1234);
      bus.bypass = 1'b0;
      idle();

      // Bypass released mid-period resumes at the right phase
      do_reset(); idle();
      bus.dec_sel = 2'd2;
      send(400);
      bus.bypass = 1'b1;
      send(1); chk("byp_k1", last_out, 1);
      send(2); chk("byp_k2", last_out, 2);
      bus.bypass = 1'b0;
      send(3); chk("byp_release", last_out, 300);
      idle();

      // dec_sel changed mid-period: D=8 completes, then D=2
      do_reset(); idle();
      bus.dec_sel = 2'd3;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) bus.dec_sel = 2'd1;
         send((i == 0) ? 80 : (i == 8) ? 200 : 0);
         a_seen[i] = last_a;
         if (i == 5) chk("mid_k5", last_out, 50);
         if (i == 8) chk("mid_anchor_val", last_out, 80);
         if (i == 9) chk("mid_k1", last_out, 140);
      end
      chk("mid_a7", a_seen[7], 0);
      chk("mid_a8", a_seen[8], 1);
      chk("mid_a9", a_seen[9], 0);
      chk("mid_a10", a_seen[10], 1);
      idle();

      // Back-to-back strobes, D=2, then async reset with dout_valid high
      do_reset(); idle();
      bus.dec_sel = 2'd1;
      valid_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         send(10 * i);
         if (i == 3) chk("b2b_mid3", last_out, 10);
         if (i == 7) chk("b2b_mid7", last_out, 50);
         chk("b2b_anchor", last_a, (i % 2 == 0) ? 1 : 0);
      end
      idle();
      chk("b2b_count", valid_cnt, 8);
      send(4321);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_data", int'(bus.dataout), 0);
      chk("async_rst_valid", int'(bus.dout_valid), 0);
      reset = 1'b0;
      send(999);
      chk("post_rst_anchor", last_a, 1);
      chk("post_rst_data", last_out, 0);
      idle();

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 15) == 0) bus.dec_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) bus.bypass = ~bus.bypass;
         if ($urandom_range(0, 199) == 0) do_reset();
         if ($urandom_range(0, 3) != 0) send(int'($signed(18'($urandom))));
         else idle();
      end
      idle();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
